// File: rtl/vga_box_renderer.sv
// vga_box_renderer
// Pixel stage behind the h/v timing generator. Draws a solid box that bounces
// off the screen edges on a black background. The box moves once per frame and
// changes colour on every bounce. RGB and both syncs leave the block through the
// same two register stages, so they stay aligned.
// Optional feature: define VGA_BOX_BORDER_EN to add a 1-pixel white border
// around the visible area. The border has priority over the box.
module vga_box_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_W    = 32,
  parameter int BOX_H    = 32,
  parameter int SPEED    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_h_count,
  input  logic [9:0]  i_v_count,
  input  logic        i_valid_area,
  input  logic        i_h_sync,
  input  logic        i_v_sync,
  input  logic        i_freeze,
  output logic [3:0]  o_red,
  output logic [3:0]  o_green,
  output logic [3:0]  o_blue,
  output logic        o_h_sync,
  output logic        o_v_sync
);

  // Geometry constants. Edge tests are done on 12-bit unsigned sums so that
  // box_x+BOX_W+SPEED can never wrap.
  localparam logic [11:0] H_ACT12 = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT12 = 12'(V_ACTIVE);
  localparam logic [11:0] BOX_W12 = 12'(BOX_W);
  localparam logic [11:0] BOX_H12 = 12'(BOX_H);
  localparam logic [11:0] SPEED12 = 12'(SPEED);
  localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BOX_W);
  localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - BOX_H);
  localparam logic [10:0] X_STEP  = 11'(SPEED);
  localparam logic [9:0]  Y_STEP  = 10'(SPEED);
  localparam logic [9:0]  V_TICK  = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    UP_LEFT    = 2'b00,
    UP_RIGHT   = 2'b01,
    DOWN_LEFT  = 2'b10,
    DOWN_RIGHT = 2'b11
  } dir_e;

  // Box state
  dir_e        dir_q, dir_d;
  logic [10:0] box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  logic [2:0]  colour_q, colour_d;

  // Motion helpers
  logic        frame_tick;
  logic        moving_right, moving_down;
  logic        flip_x, flip_y;
  logic        right_next, down_next;

  // Pixel compare
  logic [11:0] h_ext, v_ext, x_ext, y_ext;
  logic        in_box;

  // Stage 1 registers
  logic        valid_q;
  logic        in_box_q;
  logic [2:0]  colour1_q;
  logic        h_sync1_q, v_sync1_q;

  // Stage 2 registers
  logic [11:0] rgb_q, rgb_d;
  logic        h_sync2_q, v_sync2_q;

  assign h_ext = {1'b0, i_h_count};
  assign v_ext = {2'b00, i_v_count};
  assign x_ext = {1'b0, box_x_q};
  assign y_ext = {2'b00, box_y_q};

  // The first pixel of vertical blanking; the box only moves here, so it
  // never tears mid-frame.
  assign frame_tick = (i_h_count == 11'd0) && (i_v_count == V_TICK);

  assign in_box = (h_ext >= x_ext) && (h_ext < (x_ext + BOX_W12)) &&
                  (v_ext >= y_ext) && (v_ext < (y_ext + BOX_H12));

  assign moving_right = (dir_q == UP_RIGHT) || (dir_q == DOWN_RIGHT);
  assign moving_down  = (dir_q == DOWN_LEFT) || (dir_q == DOWN_RIGHT);

  // Next position, direction and colour; both axes are resolved independently
  // so a corner hit flips both but bumps the colour only once.
  always_comb begin
    box_x_d    = box_x_q;
    box_y_d    = box_y_q;
    dir_d      = dir_q;
    colour_d   = colour_q;
    flip_x     = 1'b0;
    flip_y     = 1'b0;
    right_next = moving_right;
    down_next  = moving_down;

    if (frame_tick && !i_freeze) begin
      if (moving_right) begin
        if ((x_ext + BOX_W12 + SPEED12) >= H_ACT12) begin
          box_x_d = X_MAX;
          flip_x  = 1'b1;
        end else begin
          box_x_d = box_x_q + X_STEP;
        end
      end else begin
        if (x_ext <= SPEED12) begin
          box_x_d = 11'd0;
          flip_x  = 1'b1;
        end else begin
          box_x_d = box_x_q - X_STEP;
        end
      end

      if (moving_down) begin
        if ((y_ext + BOX_H12 + SPEED12) >= V_ACT12) begin
          box_y_d = Y_MAX;
          flip_y  = 1'b1;
        end else begin
          box_y_d = box_y_q + Y_STEP;
        end
      end else begin
        if (y_ext <= SPEED12) begin
          box_y_d = 10'd0;
          flip_y  = 1'b1;
        end else begin
          box_y_d = box_y_q - Y_STEP;
        end
      end

      right_next = moving_right ^ flip_x;
      down_next  = moving_down ^ flip_y;

      case ({down_next, right_next})
        2'b00:   dir_d = UP_LEFT;
        2'b01:   dir_d = UP_RIGHT;
        2'b10:   dir_d = DOWN_LEFT;
        default: dir_d = DOWN_RIGHT;
      endcase

      // Colour cycles 1..7, skipping black so the box stays visible.
      if (flip_x || flip_y) begin
        colour_d = (colour_q == 3'b111) ? 3'b001 : (colour_q + 3'd1);
      end
    end
  end

  // Box state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dir_q    <= DOWN_RIGHT;
      box_x_q  <= 11'd0;
      box_y_q  <= 10'd0;
      colour_q <= 3'b001;
    end else begin
      dir_q    <= dir_d;
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      colour_q <= colour_d;
    end
  end

  // Stage 1: capture visibility, box hit, colour and syncs for this pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      in_box_q  <= 1'b0;
      colour1_q <= 3'b001;
      h_sync1_q <= 1'b1;
      v_sync1_q <= 1'b1;
    end else begin
      valid_q   <= i_valid_area;
      in_box_q  <= in_box;
      colour1_q <= colour_q;
      h_sync1_q <= i_h_sync;
      v_sync1_q <= i_v_sync;
    end
  end

`ifdef VGA_BOX_BORDER_EN
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  logic on_border;
  logic border_q;

  assign on_border = (i_h_count == 11'd0) || (i_h_count == H_LAST) ||
                     (i_v_count == 10'd0) || (i_v_count == V_LAST);

  // Stage 1 border flag travels alongside the box hit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      border_q <= 1'b0;
    end else begin
      border_q <= on_border;
    end
  end
`endif

  // Pixel colour selection; border (when built in) overrides the box
  always_comb begin
    rgb_d = 12'h000;
    if (valid_q && in_box_q) begin
      rgb_d = {{4{colour1_q[2]}}, {4{colour1_q[1]}}, {4{colour1_q[0]}}};
    end
`ifdef VGA_BOX_BORDER_EN
    if (valid_q && border_q) begin
      rgb_d = 12'hFFF;
    end
`endif
  end

  // Stage 2: output registers for RGB and the re-timed syncs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_q     <= 12'h000;
      h_sync2_q <= 1'b1;
      v_sync2_q <= 1'b1;
    end else begin
      rgb_q     <= rgb_d;
      h_sync2_q <= h_sync1_q;
      v_sync2_q <= v_sync1_q;
    end
  end

  assign o_red    = rgb_q[11:8];
  assign o_green  = rgb_q[7:4];
  assign o_blue   = rgb_q[3:0];
  assign o_h_sync = h_sync2_q;
  assign o_v_sync = v_sync2_q;

endmodule
